// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: N-to-1 arbiter for the req/gnt/rvalid memory protocol.
// Granted port IDs are queued in an in-order ID FIFO so that each rvalid is routed
// back to its requester. A lock keeps an ungranted request stable toward the slave.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise the
// lowest-index requester wins (fixed priority, no pointer register).
module mem_req_arbiter #(
    parameter int unsigned NR_PORTS        = 2,
    parameter int unsigned ADDRESS_SIZE    = 64,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    // requester side
    input  logic [NR_PORTS-1:0][ADDRESS_SIZE-1:0]  port_address_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]    port_data_wdata_i,
    input  logic [NR_PORTS-1:0]                    port_data_req_i,
    input  logic [NR_PORTS-1:0]                    port_data_we_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0]  port_data_be_i,
    output logic [NR_PORTS-1:0]                    port_data_gnt_o,
    output logic [NR_PORTS-1:0]                    port_data_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  port_data_rdata_o,
    // slave side
    output logic [ADDRESS_SIZE-1:0]                address_o,
    output logic [DATA_WIDTH-1:0]                  data_wdata_o,
    output logic                                   data_req_o,
    output logic                                   data_we_o,
    output logic [DATA_WIDTH/8-1:0]                data_be_o,
    input  logic                                   data_gnt_i,
    input  logic                                   data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  data_rdata_i,
    output logic                                   spurious_o
);

    localparam int unsigned IdxW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    logic [IdxW-1:0] sel;
    logic [IdxW-1:0] arb_sel;
    logic [IdxW-1:0] cand;
    logic            arb_found;
    logic            any_req;
    logic            grant;
    logic            lock_hit;

    logic            lock_valid_q, lock_valid_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;

    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] ids_q [MAX_OUTSTANDING];
    logic [IdxW-1:0] ids_d [MAX_OUTSTANDING];
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    assign any_req = |port_data_req_i;

`ifdef MEM_ARB_RR_EN
    logic [IdxW-1:0] rr_q, rr_d;

    // Round-robin search: first requester at or after the pointer.
    always_comb begin
        arb_sel   = '0;
        arb_found = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            cand = IdxW'((32'(rr_q) + i) % NR_PORTS);
            if (!arb_found && port_data_req_i[cand]) begin
                arb_found = 1'b1;
                arb_sel   = cand;
            end
        end
    end

    // Pointer moves to the port after the granted one.
    always_comb begin
        rr_d = rr_q;
        if (grant) begin
            rr_d = (32'(sel) + 1 == NR_PORTS) ? '0 : sel + IdxW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        arb_sel   = '0;
        arb_found = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            cand = IdxW'(i);
            if (!arb_found && port_data_req_i[cand]) begin
                arb_found = 1'b1;
                arb_sel   = cand;
            end
        end
    end
`endif

    // A locked port that drops its request loses the lock and arbitration reruns at once.
    assign lock_hit = lock_valid_q && port_data_req_i[lock_idx_q];
    assign sel      = lock_hit ? lock_idx_q : arb_sel;

    // Request, mux and routing outputs; full blocks requests even if a pop is in flight.
    always_comb begin
        data_req_o         = any_req && !fifo_full;
        grant              = data_req_o && data_gnt_i;
        address_o          = port_address_i[sel];
        data_wdata_o       = port_data_wdata_i[sel];
        data_we_o          = port_data_we_i[sel];
        data_be_o          = port_data_be_i[sel];
        port_data_gnt_o    = '0;
        port_data_rvalid_o = '0;
        if (grant) begin
            port_data_gnt_o[sel] = 1'b1;
        end
        if (pop) begin
            port_data_rvalid_o[ids_q[rptr_q]] = 1'b1;
        end
        spurious_o         = data_rvalid_i && fifo_empty;
        port_data_rdata_o  = data_rdata_i;
    end

    // Hold the selection while the slave sees an ungranted request.
    always_comb begin
        lock_valid_d = data_req_o && !data_gnt_i;
        lock_idx_d   = lock_valid_d ? sel : lock_idx_q;
    end

    // Lock registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_idx_q   <= lock_idx_d;
        end
    end

    assign fifo_full  = (cnt_q == CntW'(MAX_OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign push       = grant;
    assign pop        = data_rvalid_i && !fifo_empty;

    // ID FIFO next state: circular pointers, occupancy counter.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ids_d  = ids_q;
        if (push) begin
            ids_d[wptr_q] = sel;
            wptr_d = (wptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // ID FIFO registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                ids_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ids_q  <= ids_d;
        end
    end

endmodule
